// File: rtl/idex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, EX-stage fields,
// stall request and event counters out.
interface idex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              valid_i;
    logic              flush_i;
    logic [REG_W-1:0]  IFID_Rs_i;
    logic [REG_W-1:0]  IFID_Rt_i;
    logic [REG_W-1:0]  IFID_Rd_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] imm_i;
    logic              RegWrite_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              MemtoReg_i;
    logic              ALUSrc_i;
    logic              RegDst_i;
    logic [1:0]        ALUOp_i;

    logic [REG_W-1:0]  IDEX_Rs_o;
    logic [REG_W-1:0]  IDEX_Rt_o;
    logic [REG_W-1:0]  IDEX_Wr_o;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] imm_o;
    logic              RegWrite_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              MemtoReg_o;
    logic              ALUSrc_o;
    logic [1:0]        ALUOp_o;
    logic              valid_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport slave (
        input  valid_i, flush_i,
        input  IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
        input  RSdata_i, RTdata_i, imm_i,
        input  RegWrite_i, MemRead_i, MemWrite_i,
        input  MemtoReg_i, ALUSrc_i, RegDst_i, ALUOp_i,
        output IDEX_Rs_o, IDEX_Rt_o, IDEX_Wr_o,
        output RSdata_o, RTdata_o, imm_o,
        output RegWrite_o, MemRead_o, MemWrite_o,
        output MemtoReg_o, ALUSrc_o, ALUOp_o,
        output valid_o, stall_o,
        output stall_cnt_o, flush_cnt_o
    );

    modport master (
        output valid_i, flush_i,
        output IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
        output RSdata_i, RTdata_i, imm_i,
        output RegWrite_i, MemRead_i, MemWrite_i,
        output MemtoReg_i, ALUSrc_i, RegDst_i, ALUOp_i,
        input  IDEX_Rs_o, IDEX_Rt_o, IDEX_Wr_o,
        input  RSdata_o, RTdata_o, imm_o,
        input  RegWrite_o, MemRead_o, MemWrite_o,
        input  MemtoReg_o, ALUSrc_o, ALUOp_o,
        input  valid_o, stall_o,
        input  stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble
// insertion and saturating stall/flush event counters.
module idex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic            clk_i,
    input logic            rst_i,
    idex_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  wr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [1:0]        alu_op;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_t              ex_q;
    ex_t              ex_d;
    logic             hazard;
    logic             stall;
    logic             bubble;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Loads targeting $0 never create a dependency.
    always_comb begin
        hazard = ex_q.valid & ex_q.mem_read
               & (ex_q.wr != '0) & bus.valid_i
               & ((ex_q.wr == bus.IFID_Rs_i)
                | (ex_q.wr == bus.IFID_Rt_i));
        stall     = hazard & ~bus.flush_i;
        bubble    = bus.flush_i | hazard | ~bus.valid_i;
        flush_evt = bus.flush_i & bus.valid_i;
    end

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid      = 1'b1;
            ex_d.rs         = bus.IFID_Rs_i;
            ex_d.rt         = bus.IFID_Rt_i;
            ex_d.wr         = bus.RegDst_i ? bus.IFID_Rd_i
                                           : bus.IFID_Rt_i;
            ex_d.rs_data    = bus.RSdata_i;
            ex_d.rt_data    = bus.RTdata_i;
            ex_d.imm        = bus.imm_i;
            ex_d.reg_write  = bus.RegWrite_i;
            ex_d.mem_read   = bus.MemRead_i;
            ex_d.mem_write  = bus.MemWrite_i;
            ex_d.mem_to_reg = bus.MemtoReg_i;
            ex_d.alu_src    = bus.ALUSrc_i;
            ex_d.alu_op     = bus.ALUOp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_evt && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.IDEX_Rs_o   = ex_q.rs;
    assign bus.IDEX_Rt_o   = ex_q.rt;
    assign bus.IDEX_Wr_o   = ex_q.wr;
    assign bus.RSdata_o    = ex_q.rs_data;
    assign bus.RTdata_o    = ex_q.rt_data;
    assign bus.imm_o       = ex_q.imm;
    assign bus.RegWrite_o  = ex_q.reg_write;
    assign bus.MemRead_o   = ex_q.mem_read;
    assign bus.MemWrite_o  = ex_q.mem_write;
    assign bus.MemtoReg_o  = ex_q.mem_to_reg;
    assign bus.ALUSrc_o    = ex_q.alu_src;
    assign bus.ALUOp_o     = ex_q.alu_op;
    assign bus.valid_o     = ex_q.valid;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: directed load-use/flush/saturation/reset
// scenarios, then randomized traffic against a reference model.
module tb_idex_pipe_reg;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idex_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) bus ();

    idex_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        as;
        logic [1:0]  aop;
    } mex_t;

    mex_t m;
    int   scnt;
    int   fcnt;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic fl, logic [4:0] rs,
                         logic [4:0] rt, logic [4:0] rd, logic rdst,
                         logic rw, logic mr, logic mw, logic m2r,
                         logic as, logic [1:0] aop, logic [31:0] rsd,
                         logic [31:0] rtd, logic [31:0] imm);
        bus.valid_i    = v;
        bus.flush_i    = fl;
        bus.IFID_Rs_i  = rs;
        bus.IFID_Rt_i  = rt;
        bus.IFID_Rd_i  = rd;
        bus.RegDst_i   = rdst;
        bus.RegWrite_i = rw;
        bus.MemRead_i  = mr;
        bus.MemWrite_i = mw;
        bus.MemtoReg_i = m2r;
        bus.ALUSrc_i   = as;
        bus.ALUOp_i    = aop;
        bus.RSdata_i   = rsd;
        bus.RTdata_i   = rtd;
        bus.imm_i      = imm;
    endtask

    task automatic lw(logic [4:0] rt);
        drive(1, 0, 5'd1, rt, 5'd0, 0, 1, 1, 0, 1, 1, 2'd0,
              32'h100, 32'h0, 32'h4);
    endtask

    task automatic add(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        drive(1, 0, rs, rt, rd, 1, 1, 0, 0, 0, 0, 2'd2,
              32'h11, 32'h22, 32'h0);
    endtask

    // One clock: check the combinational stall, advance the model,
    // then check every registered output after the edge.
    task automatic step();
        logic hz;
        logic st;
        #1;
        hz = m.v && m.mr && (m.wr != 0) && bus.valid_i
          && (m.wr == bus.IFID_Rs_i || m.wr == bus.IFID_Rt_i);
        st = hz && !bus.flush_i;
        chk("stall_o", {63'd0, bus.stall_o}, {63'd0, st});
        if (rst) begin
            m = '0;
            scnt = 0;
            fcnt = 0;
        end else begin
            if (st) scnt = (scnt + 1 > CMAX) ? CMAX : scnt + 1;
            if (bus.flush_i && bus.valid_i)
                fcnt = (fcnt + 1 > CMAX) ? CMAX : fcnt + 1;
            if (bus.flush_i || hz || !bus.valid_i) begin
                m = '0;
            end else begin
                m.v   = 1;
                m.rs  = bus.IFID_Rs_i;
                m.rt  = bus.IFID_Rt_i;
                m.wr  = bus.RegDst_i ? bus.IFID_Rd_i : bus.IFID_Rt_i;
                m.rsd = bus.RSdata_i;
                m.rtd = bus.RTdata_i;
                m.imm = bus.imm_i;
                m.rw  = bus.RegWrite_i;
                m.mr  = bus.MemRead_i;
                m.mw  = bus.MemWrite_i;
                m.m2r = bus.MemtoReg_i;
                m.as  = bus.ALUSrc_i;
                m.aop = bus.ALUOp_i;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_o", {63'd0, bus.valid_o}, {63'd0, m.v});
        chk("regs", {49'd0, bus.IDEX_Rs_o, bus.IDEX_Rt_o, bus.IDEX_Wr_o},
            {49'd0, m.rs, m.rt, m.wr});
        chk("rs_rt_data", {bus.RSdata_o, bus.RTdata_o}, {m.rsd, m.rtd});
        chk("imm_o", {32'd0, bus.imm_o}, {32'd0, m.imm});
        chk("ctrl", {57'd0, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o,
                     bus.MemtoReg_o, bus.ALUSrc_o, bus.ALUOp_o},
            {57'd0, m.rw, m.mr, m.mw, m.m2r, m.as, m.aop});
        chk("stall_cnt", {60'd0, bus.stall_cnt_o}, 64'(scnt));
        chk("flush_cnt", {60'd0, bus.flush_cnt_o}, 64'(fcnt));
    endtask

    initial begin
        m = '0;
        scnt = 0;
        fcnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        rst = 1;
        step();
        step();
        rst = 0;

        // load-use: lw $8, then add using $8 stalls exactly one cycle
        lw(5'd8);
        step();
        add(5'd8, 5'd9, 5'd10);
        step();
        chk("lu_bubble_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("lu_bubble_mr", {63'd0, bus.MemRead_o}, 64'd0);
        step();
        chk("lu_capture_rs", {59'd0, bus.IDEX_Rs_o}, 64'd8);
        chk("lu_stall_cnt", {60'd0, bus.stall_cnt_o}, 64'd1);

        // no false stall: lw $9 vs add $8,$10; lw $0 vs add $0
        lw(5'd9);
        step();
        add(5'd8, 5'd10, 5'd11);
        step();
        chk("nofalse_valid", {63'd0, bus.valid_o}, 64'd1);
        lw(5'd0);
        step();
        add(5'd0, 5'd3, 5'd4);
        step();
        chk("zero_reg_valid", {63'd0, bus.valid_o}, 64'd1);

        // flush wins over hazard
        lw(5'd8);
        step();
        add(5'd8, 5'd9, 5'd10);
        bus.flush_i = 1;
        step();
        chk("flush_wr", {59'd0, bus.IDEX_Wr_o}, 64'd0);
        chk("flush_cnt_1", {60'd0, bus.flush_cnt_o}, 64'd1);
        chk("flush_stall_cnt", {60'd0, bus.stall_cnt_o}, 64'd1);

        // capture fidelity
        drive(1, 0, 5'd3, 5'd5, 5'd17, 1, 1, 0, 0, 0, 0, 2'd2,
              32'hDEADBEEF, 32'h12345678, 32'hFFFF8000);
        step();
        chk("cap_wr", {59'd0, bus.IDEX_Wr_o}, 64'd17);
        chk("cap_rsd", {32'd0, bus.RSdata_o}, 64'hDEADBEEF);
        chk("cap_imm", {32'd0, bus.imm_o}, 64'hFFFF8000);
        chk("cap_aop", {62'd0, bus.ALUOp_o}, 64'd2);

        // saturation: 20 load-use stalls, counter must pin at 15
        for (int i = 0; i < 20; i++) begin
            lw(5'd8);
            step();
            add(5'd8, 5'd2, 5'd3);
            step();
        end
        chk("sat_stall_cnt", {60'd0, bus.stall_cnt_o}, 64'(CMAX));

        // reset while EX holds a lw and stall is asserted
        lw(5'd8);
        step();
        add(5'd8, 5'd2, 5'd3);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_cnts", {56'd0, bus.stall_cnt_o, bus.flush_cnt_o}, 64'd0);

        // randomized traffic over a small register set
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 9) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 2) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), $urandom, $urandom, $urandom);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
